proc_clock_sequencer: RTL and testbench

// - Sequences the multicycle processor on the FPGA board. Generates the processor clock from the 50 MHz board clock.
// - Modes: free-run at a divided rate, single-step from a push-button, and halt on a PC breakpoint.
// - Replaces the free-running divider bit. Drives procMulticiclo's clock pin and the board status LEDs.

---
 rtl/proc_clock_sequencer_pkg.sv | 20 ++
 rtl/proc_clock_sequencer_step_debouncer.sv | 59 +++++
 rtl/proc_clock_sequencer.sv | 143 ++++++++++++++
 tb/tb_proc_clock_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_clock_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | proc_clock_sequencer_pkg: sequencer state encoding, sizing helper |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package proc_clock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } seq_state_e;

  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_clock_sequencer_step_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_debouncer: 2-FF sync, stability counter, press pulse         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module step_debouncer
  import proc_clock_sequencer_pkg::*;
#(
  parameter int DEBOUNCE = 500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iRaw,
  output logic oPress
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic             stable_d, stable_q;
  logic             press_d, press_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Counter only advances across consecutive disagreeing cycles.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= iRaw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign oPress = press_q;

endmodule
`default_nettype wire

// File: rtl/proc_clock_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | proc_clock_sequencer: run / single-step / breakpoint proc clock   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module proc_clock_sequencer
  import proc_clock_sequencer_pkg::*;
#(
  parameter int HALF_PERIOD = 16777216,
  parameter int DEBOUNCE    = 500000,
  parameter int PC_W        = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iRun,
  input  logic            iStep,
  input  logic            iBpEn,
  input  logic [PC_W-1:0] iBpAddr,
  input  logic [PC_W-1:0] iPC,
  output logic            oProcClock,
  output logic            oTick,
  output logic            oHalted,
  output logic [1:0]      oState
);

  localparam int               CNT_W   = cnt_width(HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  seq_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             proc_clk_d, proc_clk_q;
  logic             tick_d, tick_q;
  logic             halted_d, halted_q;
  logic             skip_bp_d, skip_bp_q;
  logic             run_prev_d, run_prev_q;
  logic             step_press, phase_end, bp_hit, run_rise;

  step_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_step_debouncer (
    .Clock  (Clock),
    .Reset  (Reset),
    .iRaw   (iStep),
    .oPress (step_press)
  );

  assign phase_end  = (cnt_q == CNT_MAX);
  assign bp_hit     = iBpEn && (iPC == iBpAddr) && !skip_bp_q;
  assign run_rise   = iRun && !run_prev_q;
  assign run_prev_d = iRun;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    proc_clk_d = proc_clk_q;
    tick_d     = 1'b0;
    skip_bp_d  = skip_bp_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        proc_clk_d = 1'b0;
        if (iRun) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d    = ST_STEP;
          proc_clk_d = 1'b1;
          tick_d     = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
        if (!proc_clk_q) begin
          if (!iRun) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (phase_end) begin
            // Breakpoint is evaluated just before the rising edge would issue.
            if (bp_hit) begin
              state_d = ST_BREAK;
            end else begin
              proc_clk_d = 1'b1;
              tick_d     = 1'b1;
              skip_bp_d  = 1'b0;
            end
          end
        end else if (phase_end) begin
          proc_clk_d = 1'b0;
          if (!iRun) state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
        if (phase_end) begin
          proc_clk_d = 1'b0;
          state_d    = iRun ? ST_RUN : ST_IDLE;
        end
      end
      ST_BREAK: begin
        cnt_d      = '0;
        proc_clk_d = 1'b0;
        if (step_press) begin
          state_d    = ST_STEP;
          skip_bp_d  = 1'b1;
          proc_clk_d = 1'b1;
          tick_d     = 1'b1;
        end else if (run_rise) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign halted_d = (state_d == ST_BREAK);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      proc_clk_q <= 1'b0;
      tick_q     <= 1'b0;
      halted_q   <= 1'b0;
      skip_bp_q  <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      proc_clk_q <= proc_clk_d;
      tick_q     <= tick_d;
      halted_q   <= halted_d;
      skip_bp_q  <= skip_bp_d;
      run_prev_q <= run_prev_d;
    end
  end

  assign oProcClock = proc_clk_q;
  assign oTick      = tick_q;
  assign oHalted    = halted_q;
  assign oState     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_clock_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_proc_clock_sequencer: vector table, corner sequences, random   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_proc_clock_sequencer;

  localparam int HP = 4;
  localparam int DB = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iRun = 1'b0, iStep = 1'b0, iBpEn = 1'b0;
  logic [15:0] iBpAddr = 16'h0005, iPC = 16'h0000;
  logic        oProcClock, oTick, oHalted;
  logic [1:0]  oState;

  int checks = 0, errors = 0, tick_cnt = 0;

  always #5 Clock = ~Clock;

  proc_clock_sequencer #(
    .HALF_PERIOD (HP),
    .DEBOUNCE    (DB),
    .PC_W        (16)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iRun       (iRun),
    .iStep      (iStep),
    .iBpEn      (iBpEn),
    .iBpAddr    (iBpAddr),
    .iPC        (iPC),
    .oProcClock (oProcClock),
    .oTick      (oTick),
    .oHalted    (oHalted),
    .oState     (oState)
  );

  // Reference model: absolute-time phase deadlines and a raw-sample history
  // window for the button (stable flips once DB delayed samples all disagree).
  int m_cyc = 0, m_state = 0, m_deadline = 0;
  bit m_clk = 0, m_tick = 0, m_skip = 0, m_runp = 0, m_stable = 0, m_press = 0;
  bit raw_hist[$];

  task automatic model_edge();
    bit press, rise, flip;
    m_cyc++;
    press   = m_press;
    rise    = iRun && !m_runp;
    m_tick  = 0;
    m_press = 0;
    if (Reset) begin
      m_state = 0; m_clk = 0; m_skip = 0; m_runp = 0; m_stable = 0;
      raw_hist.delete();
      for (int i = 0; i < DB + 2; i++) raw_hist.push_back(1'b0);
      return;
    end
    case (m_state)
      0: if (iRun) begin
           m_state = 1; m_deadline = m_cyc + HP;
         end else if (press) begin
           m_state = 2; m_clk = 1; m_tick = 1; m_deadline = m_cyc + HP;
         end
      1: if (!m_clk && !iRun) begin
           m_state = 0;
         end else if (m_cyc == m_deadline) begin
           m_deadline = m_cyc + HP;
           if (!m_clk) begin
             if (iBpEn && iPC == iBpAddr && !m_skip) m_state = 3;
             else begin m_clk = 1; m_tick = 1; m_skip = 0; end
           end else begin
             m_clk = 0;
             if (!iRun) m_state = 0;
           end
         end
      2: if (m_cyc == m_deadline) begin
           m_clk = 0; m_state = iRun ? 1 : 0; m_deadline = m_cyc + HP;
         end
      default: if (press) begin
           m_state = 2; m_skip = 1; m_clk = 1; m_tick = 1; m_deadline = m_cyc + HP;
         end else if (rise) begin
           m_state = 1; m_skip = 1; m_deadline = m_cyc + HP;
         end
    endcase
    m_runp = iRun;
    raw_hist.push_back(iStep);
    void'(raw_hist.pop_front());
    flip = 1;
    for (int i = 0; i < DB; i++) if (raw_hist[i] == m_stable) flip = 0;
    if (flip) begin m_stable = !m_stable; m_press = m_stable; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick_cycle();
    model_edge();
    @(posedge Clock);
    #1;
    check("model_proc_clock", oProcClock, m_clk);
    check("model_tick", oTick, m_tick);
    check("model_halted", oHalted, m_state == 3);
    check("model_state", oState, m_state);
    if (oTick === 1'b1) tick_cnt++;
  endtask

  task automatic do_reset();
    Reset = 1; iRun = 0; iStep = 0; iBpEn = 0; iPC = 16'h0000;
    tick_cycle();
    tick_cycle();
    Reset = 0;
  endtask

  typedef struct {
    bit          run;
    bit          step;
    bit          bpen;
    logic [15:0] addr;
    logic [15:0] pc;
    int          cycles;
    int          exp_ticks;
    int          exp_state;
  } vec_t;

  vec_t vecs[12];
  int   hi, lo, k, step_hold;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 80, 10, 1}; // free run cadence
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 20,  0, 3}; // breakpoint hit
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0005, 16'h0005, 12,  1, 2}; // press from BREAK
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005, 20,  0, 0}; // step ends in IDLE
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 14,  1, 3}; // skip once, then break
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005,  3,  0, 3};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005,  6,  1, 1}; // iRun edge resumes
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 10,  0, 3};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 20,  0, 3}; // held high: no resume
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005,  5,  0, 3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 10,  1, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0005, 16'h0005,  2,  0, 0}; // drop while low

    do_reset();
    check("reset_proc_clock", oProcClock, 0);
    check("reset_state", oState, 0);

    for (int i = 0; i < 12; i++) begin
      iRun = vecs[i].run; iStep = vecs[i].step; iBpEn = vecs[i].bpen;
      iBpAddr = vecs[i].addr; iPC = vecs[i].pc;
      tick_cnt = 0;
      repeat (vecs[i].cycles) tick_cycle();
      check($sformatf("vec%0d_ticks", i), tick_cnt, vecs[i].exp_ticks);
      check($sformatf("vec%0d_state", i), oState, vecs[i].exp_state);
    end

    // Reset in a RUN high phase, then restart latency.
    do_reset();
    iRun = 1;
    tick_cycle();
    check("run_entry_state", oState, 1);
    k = 0;
    while (oTick !== 1'b1 && k < 20) begin tick_cycle(); k++; end
    check("first_rise_latency", k, 4);
    tick_cycle();
    Reset = 1;
    tick_cycle();
    check("midrst_proc_clock", oProcClock, 0);
    check("midrst_tick", oTick, 0);
    check("midrst_state", oState, 0);
    check("midrst_halted", oHalted, 0);
    Reset = 0;
    tick_cycle();
    check("rerun_entry_state", oState, 1);
    k = 0;
    while (oTick !== 1'b1 && k < 20) begin tick_cycle(); k++; end
    check("rerun_rise_latency", k, 4);

    // Graceful stop one cycle into the high phase.
    hi = 1;
    tick_cycle();
    if (oProcClock === 1'b1) hi++;
    iRun = 0;
    for (int j = 0; j < 20 && oProcClock === 1'b1; j++) begin
      tick_cycle();
      if (oProcClock === 1'b1) hi++;
    end
    check("stop_high_len", hi, 4);
    check("stop_state", oState, 0);
    tick_cnt = 0;
    repeat (50) tick_cycle();
    check("stop_no_ticks", tick_cnt, 0);

    // Bounce rejection on press and on release.
    do_reset();
    tick_cnt = 0;
    for (int j = 0; j < 30; j++) begin iStep = ((j / 3) % 2 == 0); tick_cycle(); end
    iStep = 1;
    repeat (20) tick_cycle();
    check("bounce_press_ticks", tick_cnt, 1);
    check("bounce_back_idle", oState, 0);
    tick_cnt = 0;
    for (int j = 0; j < 30; j++) begin iStep = ((j / 3) % 2 == 1); tick_cycle(); end
    iStep = 0;
    repeat (20) tick_cycle();
    check("bounce_release_ticks", tick_cnt, 0);

    // Step into run: iRun raised during the STEP high phase.
    do_reset();
    iStep = 1;
    k = 0;
    while (oTick !== 1'b1 && k < 20) begin tick_cycle(); k++; end
    check("step_press_tick", oTick, 1);
    check("step_state", oState, 2);
    iRun = 1;
    hi = 1;
    for (int j = 0; j < 20 && oProcClock === 1'b1; j++) begin
      tick_cycle();
      if (oProcClock === 1'b1) hi++;
    end
    check("step_high_len", hi, 4);
    check("step_to_run", oState, 1);
    lo = 1;
    for (int j = 0; j < 20 && oProcClock === 1'b0; j++) begin
      tick_cycle();
      if (oProcClock === 1'b0) lo++;
    end
    check("run_low_len", lo, 4);
    check("run_rise_tick", oTick, 1);
    iStep = 0;
    hi = 1;
    for (int j = 0; j < 20 && oProcClock === 1'b1; j++) begin
      tick_cycle();
      if (oProcClock === 1'b1) hi++;
    end
    check("run_high_len", hi, 4);

    // Randomised traffic against the reference model.
    iBpEn = 1; iBpAddr = 16'h0005; step_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) iRun = ~iRun;
      if (step_hold == 0) begin
        iStep = 1'($urandom_range(0, 1));
        step_hold = $urandom_range(1, 14);
      end else begin
        step_hold--;
      end
      if ($urandom_range(0, 99) == 0) iBpEn = ~iBpEn;
      iPC = 16'($urandom_range(4, 6));
      Reset = ($urandom_range(0, 399) == 0);
      tick_cycle();
    end
    Reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
